// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The sequencer side uses the master modport.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_resetb;
  logic       sys_rst;
  logic       pll_ready;
  logic [1:0] state;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  pll_lock, relock_req,
    output pll_resetb, sys_rst, pll_ready, state, retry_count, loss_count
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_resetb, sys_rst, pll_ready, state, retry_count, loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up and lock supervisor for the PLL: holds PLL reset, waits for a stable lock, then
// releases the fabric reset. Retries on lock timeout and re-sequences on lock loss.
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 12000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    StResetPll  = 2'd0,
    StWaitLock  = 2'd1,
    StStabilize = 2'd2,
    StRun       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ResetLast   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync_q, lock_s_q;
  logic             pll_resetb_q, sys_rst_q, pll_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      // relock_req is deliberately ignored here so the full dwell always completes.
      StResetPll: begin
        if (cnt_q == ResetLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (bus.relock_req) begin
          state_d = StResetPll;
          cnt_d   = '0;
        end else if (lock_s_q) begin
          state_d = StStabilize;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResetPll;
          cnt_d   = '0;
          retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        end
      end
      StStabilize: begin
        if (bus.relock_req) begin
          state_d = StResetPll;
          cnt_d   = '0;
        end else if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        // Lock loss outranks relock_req so a simultaneous request still gets counted.
        if (!lock_s_q) begin
          state_d = StResetPll;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else if (bus.relock_req) begin
          state_d = StResetPll;
        end
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StResetPll;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      sync_q       <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      pll_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      sync_q       <= bus.pll_lock;
      lock_s_q     <= sync_q;
      pll_resetb_q <= (state_d != StResetPll);
      sys_rst_q    <= (state_d != StRun);
      pll_ready_q  <= (state_d == StRun);
    end
  end

  assign bus.state       = state_q;
  assign bus.pll_resetb  = pll_resetb_q;
  assign bus.sys_rst     = sys_rst_q;
  assign bus.pll_ready   = pll_ready_q;
  assign bus.retry_count = retry_q;
  assign bus.loss_count  = loss_q;

endmodule
